// File: rtl/bishift_sched_8_pkg.sv
// Shared constants and state encoding for the bishift_sched_8 scheduler slice.
// The shifter datapath and the scheduler both import this package.
package bishift_sched_8_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS1 = 2'd1;
  localparam logic [1:0] ST_PASS2 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PASS1 = ST_PASS1,
    PASS2 = ST_PASS2,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/bishift_series_8.sv
// Combinational 8-bit bidirectional logical shifter built as three series
// stages (1, 2, 4); vacated bit positions are filled with zeros.
module bishift_series_8
  import bishift_sched_8_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  s_sel,
  input  logic              right,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] st1;
  logic [DATA_W-1:0] st2;

  always_comb begin
    st1 = data;
    if (s_sel[0]) st1 = right ? (data >> 1) : (data << 1);
    st2 = st1;
    if (s_sel[1]) st2 = right ? (st1 >> 2) : (st1 << 2);
    out = st2;
    if (s_sel[2]) out = right ? (st2 >> 4) : (st2 << 4);
  end

endmodule

// File: rtl/bishift_sched_8.sv
// Two-requester scheduler around one shared bishift_series_8: logical shifts
// take one shifter pass, rotates take two opposite-direction passes ORed.
module bishift_sched_8
  import bishift_sched_8_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_right,
  input  logic              req0_rot,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_right,
  input  logic              req1_rot,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id
);

  // Handshakes: a request transfers on the rising edge where reqX_valid and
  // reqX_ready are both high; the result transfers where res_valid and
  // res_ready are both high. Valid and payload must be held until ready.

  state_e            state;
  state_e            state_nx;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  logic              op_right;
  logic              op_rot;
  logic              op_id;
  logic              last_grant;
  logic [DATA_W-1:0] acc;

  logic              accept;
  logic              grant_id;
  logic [AMT_W-1:0]  sh_amt;
  logic              sh_right;
  logic [DATA_W-1:0] sh_out;

  // last_grant==1 means requester 0 holds priority on a tie.
  always_comb begin
    req0_ready = !rst && (state == IDLE) && req0_valid &&
                 (!req1_valid || last_grant || !RR_EN);
    req1_ready = !rst && (state == IDLE) && req1_valid && !req0_ready;
    accept     = req0_ready || req1_ready;
    grant_id   = req1_ready;
  end

  // Second rotate pass: 8-n wraps naturally in AMT_W bits (n is never 0 here).
  always_comb begin
    sh_amt   = op_amt;
    sh_right = op_right;
    if (state == PASS2) begin
      sh_amt   = AMT_W'(0) - op_amt;
      sh_right = !op_right;
    end
  end

  bishift_series_8 u_shift (
    .data  (op_data),
    .s_sel (sh_amt),
    .right (sh_right),
    .out   (sh_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = PASS1;
      PASS1:   state_nx = (op_rot && (op_amt != '0)) ? PASS2 : DONE;
      PASS2:   state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_data    <= '0;
      op_amt     <= '0;
      op_right   <= 1'b0;
      op_rot     <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      acc        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            op_data    <= grant_id ? req1_data  : req0_data;
            op_amt     <= grant_id ? req1_amt   : req0_amt;
            op_right   <= grant_id ? req1_right : req0_right;
            op_rot     <= grant_id ? req1_rot   : req0_rot;
            op_id      <= grant_id;
            last_grant <= grant_id;
          end
        end
        PASS1:   acc <= sh_out;
        PASS2:   acc <= acc | sh_out;
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = acc;
  assign res_id    = op_id;

endmodule

// File: tb/tb_bishift_sched_8.sv
// Self-checking bench for bishift_sched_8: round-robin and fixed-priority
// instances, expected results queued at issue and checked at output.
module tb_bishift_sched_8;
  import bishift_sched_8_pkg::*;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req0_right, req0_rot;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_right, req1_rot;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       res_valid, res_ready, res_id;
  logic [7:0] res_data;

  logic       fp_req0_valid, fp_req0_ready, fp_req0_right, fp_req0_rot;
  logic [7:0] fp_req0_data;
  logic [2:0] fp_req0_amt;
  logic       fp_req1_valid, fp_req1_ready, fp_req1_right, fp_req1_rot;
  logic [7:0] fp_req1_data;
  logic [2:0] fp_req1_amt;
  logic       fp_res_valid, fp_res_ready, fp_res_id;
  logic [7:0] fp_res_data;

  logic [8:0] exp_q[$];
  int         n_checks;
  int         n_pass;
  bit         last_served;

  bishift_sched_8 #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_right(req0_right), .req0_rot(req0_rot),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_right(req1_right), .req1_rot(req1_rot),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id)
  );

  bishift_sched_8 #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_data(fp_req0_data),
    .req0_amt(fp_req0_amt), .req0_right(fp_req0_right), .req0_rot(fp_req0_rot),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_data(fp_req1_data),
    .req1_amt(fp_req1_amt), .req1_right(fp_req1_right), .req1_rot(fp_req1_rot),
    .res_valid(fp_res_valid), .res_ready(fp_res_ready), .res_data(fp_res_data),
    .res_id(fp_res_id)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                       input bit rt, input bit ro);
    logic [15:0] dd;
    logic [7:0]  s;
    dd = {d, d};
    if (!ro) begin
      s = rt ? (d >> a) : (d << a);
      return s;
    end
    if (rt) begin
      dd = dd >> a;
      return dd[7:0];
    end
    dd = dd << a;
    return dd[15:8];
  endfunction

  // Driver: present one request, wait for its grant, drop valid after accept.
  task automatic send(input bit r, input logic [7:0] d, input logic [2:0] a,
                      input bit rt, input bit ro, output bit ok);
    bit granted;
    granted = 1'b0;
    if (r) begin
      req1_data = d; req1_amt = a; req1_right = rt; req1_rot = ro; req1_valid = 1'b1;
    end else begin
      req0_data = d; req0_amt = a; req0_right = rt; req0_rot = ro; req0_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((r ? req1_ready : req0_ready) === 1'b1) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    ok = granted && ((r ? req1_ready : req0_ready) === 1'b0);
    if (granted) begin
      exp_q.push_back({r, model(d, a, rt, ro)});
      last_served = r;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until res_valid is seen.
  task automatic wait_valid(output int cyc, output bit saw_p2);
    cyc = 1;
    saw_p2 = 1'b0;
    #1;
    while (res_valid !== 1'b1 && cyc < 20) begin
      if (dut.state === ST_PASS2) saw_p2 = 1'b1;
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
    else n_pass++;
    n_checks++;
    if ({res_valid, res_id, res_data} !== 10'h0) $display("FAIL reset_outputs got v=%b id=%b d=%h want 0 0 00", res_valid, res_id, res_data);
    else n_pass++;
    n_checks++;
    if (dut.state !== ST_IDLE || fp_res_valid !== 1'b0) $display("FAIL reset_state got %0d fpv=%b want 0 0", dut.state, fp_res_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL first_winner got %b%b want 10", req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    last_served = 1'b1;
  endtask

  task automatic test_shift;
    bit ok, p2;
    int cyc;
    logic [8:0] exp;
    send(1'b0, 8'hB4, 3'd3, 1'b1, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL shift_grant_pulse got ok=%b want 1", ok);
    else n_pass++;
    wait_valid(cyc, p2);
    n_checks++;
    if (cyc !== 2) $display("FAIL shift_latency got %0d want 2", cyc);
    else n_pass++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
    n_checks++;
    if ({res_id, res_data} !== exp || res_data !== 8'h16) $display("FAIL shift_result got %b/%h want %h (16)", res_id, res_data, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rotate;
    logic [7:0] d_t[2]   = '{8'h81, 8'h0F};
    logic [2:0] a_t[2]   = '{3'd1, 3'd4};
    bit         r_t[2]   = '{1'b0, 1'b1};
    logic [7:0] e_t[2]   = '{8'h03, 8'hF0};
    bit ok, p2;
    int cyc;
    logic [8:0] exp;
    for (int k = 0; k < 2; k++) begin
      send(1'b1, d_t[k], a_t[k], r_t[k], 1'b1, ok);
      wait_valid(cyc, p2);
      n_checks++;
      if (!ok || cyc !== 3) $display("FAIL rot_latency[%0d] got ok=%b cyc=%0d want 1 3", k, ok, cyc);
      else n_pass++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
      n_checks++;
      if ({res_id, res_data} !== exp || res_data !== e_t[k]) $display("FAIL rot_result[%0d] got %b/%h want %h", k, res_id, res_data, e_t[k]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    bit next_g, g;
    int grants;
    logic [8:0] exp;
    res_ready = 1'b1;
    req0_data = 8'hA5; req0_amt = 3'd1; req0_right = 1'b0; req0_rot = 1'b0;
    req1_data = 8'h3C; req1_amt = 3'd2; req1_right = 1'b1; req1_rot = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    next_g = !last_served;
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        g = req1_ready;
        n_checks++;
        if (g !== next_g || (req0_ready & req1_ready)) $display("FAIL rr_grant_order got %b want %b", g, next_g);
        else n_pass++;
        exp_q.push_back(g ? {1'b1, model(8'h3C, 3'd2, 1'b1, 1'b1)} : {1'b0, model(8'hA5, 3'd1, 1'b0, 1'b0)});
        next_g = !g;
        grants++;
      end
      if (res_valid === 1'b1) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
        n_checks++;
        if ({res_id, res_data} !== exp) $display("FAIL rr_result got %b/%h want %b/%h", res_id, res_data, exp[8], exp[7:0]);
        else n_pass++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (res_valid === 1'b1) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
        n_checks++;
        if ({res_id, res_data} !== exp) $display("FAIL rr_drain got %b/%h want %b/%h", res_id, res_data, exp[8], exp[7:0]);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (grants < 8 || exp_q.size() != 0) $display("FAIL rr_progress got grants=%0d left=%0d want >=8 0", grants, exp_q.size());
    else n_pass++;
    last_served = !next_g;
  endtask

  task automatic test_fixed_prio;
    int grants;
    bit seen1;
    fp_res_ready = 1'b1;
    fp_req0_data = 8'h96; fp_req0_amt = 3'd2; fp_req0_right = 1'b1; fp_req0_rot = 1'b0;
    fp_req1_data = 8'h11; fp_req1_amt = 3'd4; fp_req1_right = 1'b0; fp_req1_rot = 1'b1;
    fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
    grants = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (fp_req0_ready === 1'b1 || fp_req1_ready === 1'b1) begin
        n_checks++;
        if (fp_req1_ready !== 1'b0) $display("FAIL fp_grant got req1 want req0");
        else n_pass++;
        grants++;
      end
      if (fp_res_valid === 1'b1) begin
        n_checks++;
        if ({fp_res_id, fp_res_data} !== {1'b0, 8'h25}) $display("FAIL fp_result got %b/%h want 0/25", fp_res_id, fp_res_data);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (grants < 5) $display("FAIL fp_progress got %0d want >=5", grants);
    else n_pass++;
    fp_req0_valid = 1'b0;
    seen1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fp_req1_ready === 1'b1) begin
        seen1 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen1) $display("FAIL fp_req1_after_release got 0 want 1");
    else n_pass++;
    @(negedge clk);
    fp_req1_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stall;
    bit ok, p2, bad;
    int cyc;
    logic [8:0] exp;
    res_ready = 1'b0;
    send(1'b0, 8'h3C, 3'd2, 1'b0, 1'b0, ok);
    wait_valid(cyc, p2);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
    n_checks++;
    if (!ok || cyc !== 2 || {res_id, res_data} !== exp || res_data !== 8'hF0) $display("FAIL stall_first got cyc=%0d %b/%h want 2 0/f0", cyc, res_id, res_data);
    else n_pass++;
    req1_data = 8'h81; req1_amt = 3'd3; req1_right = 1'b1; req1_rot = 1'b1; req1_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if ({res_valid, res_id, res_data} !== {1'b1, exp} || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (bad) $display("FAIL stall_hold got v=%b %b/%h rdy=%b%b want 1 %h 00", res_valid, res_id, res_data, req0_ready, req1_ready, exp);
    else n_pass++;
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b0) $display("FAIL stall_early_grant got %b want 0", req1_ready);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (req1_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL stall_next_accept got rdy=%b v=%b want 1 0", req1_ready, res_valid);
    else n_pass++;
    exp_q.push_back({1'b1, model(8'h81, 3'd3, 1'b1, 1'b1)});
    last_served = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_valid(cyc, p2);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
    n_checks++;
    if (cyc !== 3 || {res_id, res_data} !== exp || res_data !== 8'h30) $display("FAIL stall_second got cyc=%0d %b/%h want 3 1/30", cyc, res_id, res_data);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    bit ok, bad;
    send(1'b0, 8'hC3, 3'd2, 1'b0, 1'b1, ok);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    #1;
    n_checks++;
    if (!ok || dut.state !== ST_PASS2) $display("FAIL midop_in_pass2 got ok=%b st=%0d want 1 2", ok, dut.state);
    else n_pass++;
    rst = 1'b1;
    req1_data = 8'h01; req1_amt = 3'd1; req1_right = 1'b0; req1_rot = 1'b0; req1_valid = 1'b1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b0) $display("FAIL midop_ready_in_rst got %b want 0", req1_ready);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (dut.state !== ST_IDLE || {res_valid, res_id, res_data} !== 10'h0) $display("FAIL midop_reset got st=%0d v=%b %b/%h want 0 0 0/00", dut.state, res_valid, res_id, res_data);
    else n_pass++;
    rst = 1'b0;
    req1_valid = 1'b0;
    last_served = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (res_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL midop_no_result got res_valid=1 want 0");
    else n_pass++;
  endtask

  task automatic test_amt_zero;
    bit ok, p2;
    int cyc;
    logic [8:0] exp;
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 8'h5A, 3'd0, k[0], k[1], ok);
      wait_valid(cyc, p2);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
      n_checks++;
      if (!ok || cyc !== 2 || p2) $display("FAIL amt0_timing[%0d] got cyc=%0d pass2=%b want 2 0", k, cyc, p2);
      else n_pass++;
      n_checks++;
      if ({res_id, res_data} !== exp || res_data !== 8'h5A) $display("FAIL amt0_result[%0d] got %b/%h want 0/5a", k, res_id, res_data);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; last_served = 1'b1;
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_right = 1'b0; req0_rot = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_right = 1'b0; req1_rot = 1'b0;
    fp_res_ready = 1'b1;
    fp_req0_valid = 1'b0; fp_req0_data = '0; fp_req0_amt = '0; fp_req0_right = 1'b0; fp_req0_rot = 1'b0;
    fp_req1_valid = 1'b0; fp_req1_data = '0; fp_req1_amt = '0; fp_req1_right = 1'b0; fp_req1_rot = 1'b0;
    @(negedge clk);
    test_reset();
    test_shift();
    test_rotate();
    test_back_to_back();
    test_fixed_prio();
    test_stall();
    test_reset_midop();
    test_amt_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
